// File: rtl/psum_channel_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : npu_pkg
//  Description : Shared types and constants for the partial-sum channel
//                scheduler: scheduler state encoding, accumulator channel
//                index width and accumulator tile latency.
//  Revision    : 1.0 - initial release
// ============================================================================
package npu_pkg;

    // Width of the accumulator cal_chan port.
    localparam int CHAN_W = 4;

    // Default accumulator column-sweep length (accumulator W).
    localparam int ACC_CYCLES_DEFAULT = 11;

    // Cycles from one accepted tile to the earliest next one: the sweep plus
    // the load and done steps of the accumulator.
    localparam int ACC_LATENCY = ACC_CYCLES_DEFAULT + 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        WAIT  = 3'd2,
        ACCUM = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/psum_channel_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : psum_channel_scheduler
//  Description : Sequences the partial-sum accumulator over the input
//                channels and output channels of a conv layer. For each
//                output channel it clears the accumulator, feeds NUM_CHAN
//                conv tiles one at a time, waits for the accumulator's final
//                out_valid and hands the finished map downstream.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                start              - begin a layer (honoured only in IDLE)
//                conv_valid/ready   - tile handshake with the conv engine
//                acc_in_valid       - one-cycle pulse per accepted tile
//                acc_chan           - channel index for the accumulator
//                acc_clear          - one-cycle accumulator clear
//                acc_out_valid      - accumulator final-channel complete
//                res_valid/ready    - finished-map handshake downstream
//                och_idx            - output channel being built/presented
//                busy               - high outside IDLE
//                layer_done         - one-cycle pulse after the last map
//  Revision    : 1.0 - initial release
// ============================================================================
module psum_channel_scheduler
    import npu_pkg::*;
#(
    parameter int NUM_CHAN   = 10,
    parameter int NUM_OCH    = 8,
    parameter int ACC_CYCLES = ACC_CYCLES_DEFAULT,
    parameter int OCH_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              conv_valid,
    output logic              conv_ready,
    output logic              acc_in_valid,
    output logic [CHAN_W-1:0] acc_chan,
    output logic              acc_clear,
    input  logic              acc_out_valid,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [OCH_W-1:0]  och_idx,
    output logic              busy,
    output logic              layer_done
);

    // Tile latency re-based onto this instance's sweep length.
    localparam int c_LAT   = ACC_LATENCY - ACC_CYCLES_DEFAULT + ACC_CYCLES;
    localparam int c_CNT_W = $clog2(c_LAT);

    // The pulse cycle is the first ACCUM cycle (cnt=0). Leaving ACCUM on the
    // edge where cnt advances to ACC_CYCLES+1 puts the next WAIT exactly
    // c_LAT-1 cycles after the pulse, so back-to-back tiles land c_LAT apart.
    localparam logic [c_CNT_W-1:0] c_CNT_EXIT  = c_CNT_W'(c_LAT - 2);
    localparam logic [CHAN_W-1:0]  c_CHAN_LAST = CHAN_W'(NUM_CHAN - 1);
    localparam logic [OCH_W-1:0]   c_OCH_LAST  = OCH_W'(NUM_OCH - 1);

    sched_state_t        r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [CHAN_W-1:0]   r_chan;
    logic [OCH_W-1:0]    r_och;
    logic                r_acc_in_valid;
    logic                r_res_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_chan         <= '0;
            r_och          <= '0;
            r_acc_in_valid <= 1'b0;
            r_res_valid    <= 1'b0;
        end else begin
            r_acc_in_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_och   <= '0;
                        r_state <= CLEAR;
                    end
                end
                CLEAR: begin
                    r_chan  <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (conv_valid) begin
                        r_acc_in_valid <= 1'b1;
                        r_cnt          <= '0;
                        r_state        <= ACCUM;
                    end
                end
                ACCUM: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_EXIT) begin
                        if (r_chan == c_CHAN_LAST) begin
                            r_state <= DRAIN;
                        end else begin
                            r_chan  <= r_chan + 1'b1;
                            r_state <= WAIT;
                        end
                    end
                end
                DRAIN: begin
                    // res_valid must be seen high for at least one cycle, so
                    // res_ready is only honoured once res_valid is already up.
                    if (!r_res_valid) begin
                        if (acc_out_valid) begin
                            r_res_valid <= 1'b1;
                        end
                    end else if (res_ready) begin
                        r_res_valid <= 1'b0;
                        if (r_och == c_OCH_LAST) begin
                            r_state <= DONE;
                        end else begin
                            r_och   <= r_och + 1'b1;
                            r_state <= CLEAR;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Remaining outputs are pure decodes of the registered state.
    assign conv_ready   = (r_state == WAIT);
    assign acc_clear    = (r_state == CLEAR);
    assign busy         = (r_state != IDLE);
    assign layer_done   = (r_state == DONE);
    assign acc_in_valid = r_acc_in_valid;
    assign acc_chan     = r_chan;
    assign res_valid    = r_res_valid;
    assign och_idx      = r_och;

endmodule

`default_nettype wire

// File: tb/tb_psum_channel_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psum_channel_scheduler
//  Description : Self-checking bench for psum_channel_scheduler. Drives tiles,
//                accumulator completions and downstream readiness with random
//                gaps, and checks the scheduler against the layer/tile timing
//                rules computed directly in the bench.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_channel_scheduler;

    localparam int NUM_CHAN   = 10;
    localparam int NUM_OCH    = 8;
    localparam int ACC_CYCLES = 11;
    localparam int OCH_W      = 3;
    localparam int LAT        = ACC_CYCLES + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             conv_valid;
    logic             conv_ready;
    logic             acc_in_valid;
    logic [3:0]       acc_chan;
    logic             acc_clear;
    logic             acc_out_valid;
    logic             res_valid;
    logic             res_ready;
    logic [OCH_W-1:0] och_idx;
    logic             busy;
    logic             layer_done;

    int n_checks = 0;
    int n_errors = 0;

    // Event counters, sampled mid-cycle where inputs and outputs are stable.
    int mon_inv  = 0;
    int mon_clr  = 0;
    int mon_done = 0;
    int mon_hs   = 0;

    always #5 clk = ~clk;

    psum_channel_scheduler #(
        .NUM_CHAN   (NUM_CHAN),
        .NUM_OCH    (NUM_OCH),
        .ACC_CYCLES (ACC_CYCLES),
        .OCH_W      (OCH_W)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .conv_valid    (conv_valid),
        .conv_ready    (conv_ready),
        .acc_in_valid  (acc_in_valid),
        .acc_chan      (acc_chan),
        .acc_clear     (acc_clear),
        .acc_out_valid (acc_out_valid),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .och_idx       (och_idx),
        .busy          (busy),
        .layer_done    (layer_done)
    );

    always @(negedge clk) begin
        if (acc_in_valid)           mon_inv  <= mon_inv + 1;
        if (acc_clear)              mon_clr  <= mon_clr + 1;
        if (layer_done)             mon_done <= mon_done + 1;
        if (res_valid && res_ready) mon_hs   <= mon_hs + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until the scheduler offers to take a tile.
    task automatic wait_ready();
        logic ok;
        ok = conv_ready;
        for (int i = 0; i < 40 && !ok; i++) begin
            conv_valid = 1'($urandom_range(0, 1));
            step();
            ok = conv_ready;
        end
        chk("ready_wait", ok, 1);
    endtask

    // Feed one tile. On return the sample is the cycle LAT-1 after the pulse.
    task automatic feed_tile(input int ch, input int stall, input logic last, input logic early_ov);
        logic bad;
        wait_ready();
        chk("chan_in_wait", acc_chan, ch);
        bad = 1'b0;
        for (int j = 0; j < stall; j++) begin
            conv_valid    = 1'b0;
            acc_out_valid = (j == 0);
            res_ready     = (j == 1);
            step();
            if (!conv_ready || acc_in_valid || acc_chan != 4'(ch) || res_valid)
                bad = 1'b1;
        end
        acc_out_valid = 1'b0;
        res_ready     = 1'b0;
        if (stall > 0) chk("stall_hold", bad, 0);
        conv_valid = 1'b1;
        step();
        chk("pulse", acc_in_valid, 1);
        chk("pulse_chan", acc_chan, ch);
        chk("ready_drop", conv_ready, 0);
        bad = 1'b0;
        for (int k = 1; k <= LAT - 1; k++) begin
            conv_valid    = 1'($urandom_range(0, 1));
            acc_out_valid = early_ov && (k == LAT - 1);
            step();
            if (k < LAT - 1 && (conv_ready || acc_in_valid || acc_chan != 4'(ch) || res_valid))
                bad = 1'b1;
        end
        acc_out_valid = 1'b0;
        conv_valid    = 1'b0;
        chk("accum_quiet", bad, 0);
        chk("reenter_wait", conv_ready, !last);
        if (!last) chk("chan_next", acc_chan, ch + 1);
    endtask

    // Finish one output map: completion, backpressure, handoff.
    task automatic drain(input int o, input int bp, input logic same_cycle, input logic last);
        logic bad;
        int   n;
        bad = 1'b0;
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) begin
            res_ready = 1'($urandom_range(0, 1));
            step();
            if (res_valid || conv_ready || !busy || och_idx != OCH_W'(o)) bad = 1'b1;
        end
        chk("drain_idle", bad, 0);
        acc_out_valid = 1'b1;
        res_ready     = same_cycle;
        step();
        acc_out_valid = 1'b0;
        chk("res_rise", res_valid, 1);
        chk("res_och", och_idx, o);
        bad = 1'b0;
        for (int j = 0; j < bp; j++) begin
            res_ready = 1'b0;
            step();
            if (!res_valid || och_idx != OCH_W'(o) || acc_clear) bad = 1'b1;
        end
        if (bp > 0) chk("bp_hold", bad, 0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("res_drop", res_valid, 0);
        if (!last) begin
            chk("next_clear", acc_clear, 1);
            chk("next_och", och_idx, o + 1);
        end else begin
            chk("done_pulse", layer_done, 1);
            step();
            chk("done_once", layer_done, 0);
            chk("idle_after", busy, 0);
        end
    endtask

    task automatic run_layer(input int stall_och, input logic rand_gaps, input int bp_och,
                             input int start_och);
        int b_inv, b_clr, b_done, b_hs, st, bp;
        b_inv = mon_inv; b_clr = mon_clr; b_done = mon_done; b_hs = mon_hs;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("clear_after_start", acc_clear, 1);
        chk("och_start", och_idx, 0);
        chk("busy_start", busy, 1);
        for (int o = 0; o < NUM_OCH; o++) begin
            // Sample is in CLEAR; res_ready here must not matter.
            res_ready = 1'($urandom_range(0, 1));
            step();
            res_ready = 1'b0;
            chk("clear_one_cycle", acc_clear, 0);
            chk("wait_after_clear", conv_ready, 1);
            for (int ch = 0; ch < NUM_CHAN; ch++) begin
                if (o == start_och && ch == 4) begin
                    start = 1'b1;
                    step();
                    start = 1'b0;
                    chk("start_ignored", {acc_clear, conv_ready, och_idx}, {2'b01, OCH_W'(o)});
                end
                if (o == stall_och && ch == 3) st = 20;
                else if (rand_gaps)            st = $urandom_range(0, 2);
                else                           st = 0;
                feed_tile(ch, st, ch == NUM_CHAN - 1, 1'($urandom_range(0, 1)));
            end
            bp = (o == bp_och) ? 50 : (rand_gaps ? $urandom_range(0, 4) : 0);
            drain(o, bp, 1'($urandom_range(0, 1)), o == NUM_OCH - 1);
        end
        step();
        chk("layer_pulses", mon_inv - b_inv, NUM_OCH * NUM_CHAN);
        chk("layer_clears", mon_clr - b_clr, NUM_OCH);
        chk("layer_dones", mon_done - b_done, 1);
        chk("layer_hs", mon_hs - b_hs, NUM_OCH);
    endtask

    initial begin
        logic bad;
        rst = 1'b1; start = 1'b0; conv_valid = 1'b0; acc_out_valid = 1'b0; res_ready = 1'b0;
        repeat (3) step();
        chk("rst_outputs",
            {busy, conv_ready, acc_in_valid, acc_clear, res_valid, layer_done, acc_chan, och_idx}, 0);
        rst = 1'b0;

        // IDLE ignores tiles, completions and readiness.
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            conv_valid = 1'b1; acc_out_valid = 1'($urandom_range(0, 1)); res_ready = 1'b1;
            step();
            if (busy || conv_ready || acc_in_valid || res_valid || acc_clear) bad = 1'b1;
        end
        conv_valid = 1'b0; acc_out_valid = 1'b0; res_ready = 1'b0;
        chk("idle_ignores", bad, 0);

        // Layer with back-to-back tiles, a 20-cycle stall on och 2 chan 3,
        // 50 cycles of backpressure on och 0 and a stray start on och 5.
        run_layer(2, 1'b0, 0, 5);

        // Reset in the middle of ACCUM for chan 5.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int ch = 0; ch < 5; ch++) feed_tile(ch, 0, 1'b0, 1'b0);
        chk("pre_rst_chan", acc_chan, 5);
        conv_valid = 1'b1;
        step();
        conv_valid = 1'b0;
        chk("pre_rst_pulse", acc_in_valid, 1);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_outputs",
            {busy, conv_ready, acc_in_valid, acc_clear, res_valid, layer_done, acc_chan, och_idx}, 0);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            conv_valid = 1'b1; acc_out_valid = 1'($urandom_range(0, 1));
            step();
            if (busy || acc_in_valid || acc_clear || res_valid || layer_done) bad = 1'b1;
        end
        conv_valid = 1'b0; acc_out_valid = 1'b0;
        chk("post_rst_quiet", bad, 0);

        // Fresh layer after the abort, with random gaps throughout.
        run_layer($urandom_range(0, NUM_OCH - 1), 1'b1, $urandom_range(0, NUM_OCH - 1), NUM_OCH);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
